req_gnt_requester: RTL and testbench
====================================

// Module: req_gnt_requester
// PURPOSE
//  Requester side of the team's req/gnt one-hot arbitration interface.
//  - Collects job pulses from NUM_PORTS clients and keeps a saturating
//    pending-job count per client.
//  - Drives req_o into a one-hot arbiter and accepts the returned gnt_i.
//  - Each grant runs one BURST_LEN-beat service burst for the granted port.
//  - Sits between client job sources and the shared-resource arbiter.
// PARAMETERS
//  NUM_PORTS  4  number of clients; width of req_o, gnt_i, job_i
//  BURST_LEN  4  beats per granted service burst (>=1)
//  MAX_PEND   3  saturation limit of each pending counter (>=1)
// PORTS
//  clk          in   1                 single clock, rising edge
//  reset        in   1                 asynchronous, active-high
//  job_i        in   NUM_PORTS         per-port job pulse, +1 pending
//  req_o        out  NUM_PORTS         to arbiter: port has pending work
//  gnt_i        in   NUM_PORTS         from arbiter: one-hot grant
//  busy_o       out  1                 service burst in progress
//  port_o       out  $clog2(NUM_PORTS) binary index of port being served
//  beat_o       out  $clog2(BURST_LEN) beat index within burst, 0..BURST_LEN-1
//  done_o       out  NUM_PORTS         1-cycle pulse on last beat, bit = port
//  ovf_o        out  NUM_PORTS         1-cycle pulse: job dropped, counter at MAX_PEND
//  err_o        out  1                 sticky protocol error
// BEHAVIOUR
//  - Reset: all counters 0, state IDLE. Outputs req_o, busy_o, port_o,
//    beat_o, done_o, ovf_o and err_o are all 0.
//  - Counters: cnt[i] is CNT_W = $clog2(MAX_PEND+1) bits.
//    - job_i[i] increments cnt[i]; at MAX_PEND the job is dropped and ovf_o[i] pulses.
//    - A job and a completion on the same port in the same cycle: net count unchanged.
//  - req_o[i] = (cnt[i]!=0) & (state==IDLE). Combinational from registers only.
//  - FSM IDLE:
//    - gnt_i==0: stay in IDLE.
//    - gnt_i one-hot on a requesting port: latch its index into port_o,
//      set beat=0, go to BUSY.
//  - FSM BUSY:
//    - busy_o=1, req_o=0, beat_o increments each cycle.
//    - On beat==BURST_LEN-1: done_o[port_o]=1, cnt[port_o] decrements
//      at that edge, go to IDLE.
//  - Latency:
//    - job at edge t -> req_o high in cycle t+1.
//    - Same-cycle grant -> busy_o from t+2 through t+1+BURST_LEN.
//    - req_o reasserts the cycle after done_o if work remains.
//  - BURST_LEN=1: BUSY lasts exactly one cycle; done_o pulses in it.
//  - Protocol errors set err_o (sticky until reset). The grant is ignored
//    and state does not change.
//    - gnt_i not one-hot (more than one bit set).
//    - gnt_i bit set on a port with req_o=0.
//    - any gnt_i bit set while in BUSY.
//  - Reset mid-burst: burst aborted, no done_o, all counts cleared.
//  - port_o and beat_o hold their last value in IDLE; they are valid only when busy_o=1.
// CONFIGURATION
//  - Macro REQ_GNT_STATS_EN.
//  - Defined: adds output grant_cnt_o [31:0].
//    - Counts accepted grants; wraps at 2^32; reset 0.
//    - Adds output drop_cnt_o [15:0]: total ovf_o events, saturating at 16'hFFFF.
//  - Undefined: both ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package req_gnt_pkg:
//    - typedef enum logic {IDLE, BUSY} rg_state_e.
//    - function onehot_chk(): returns 1 if exactly one bit is set.
//  - Sub-module pend_counter (one per port, generate loop):
//    - Saturating up/down counter.
//    - Inputs inc, dec; outputs nonzero, ovf.
//  - Top: FSM, beat counter, one-hot-to-binary grant encoder, error logic.
// TESTING
//  Bench: NUM_PORTS=4, BURST_LEN=4, MAX_PEND=3, driven by a fixed-priority
//  arbiter (port0 highest) on req_o/gnt_i.
//  1. Single job: job_i=4'b0100 for 1 cycle.
//     -> req_o=4'b0100 next cycle; busy_o 4 cycles with port_o=2,
//        beat_o 0..3; done_o=4'b0100 on beat 3; then req_o=0.
//  2. Contention: job_i=4'b1111 in one cycle.
//     -> four bursts in port order 0,1,2,3, back-to-back with 1 IDLE
//        cycle between them; 20 cycles total to the last done_o.
//  3. Saturation: 5 job pulses on port1 with no grant (bench forces gnt_i=0).
//     -> cnt=3; ovf_o[1] pulses on the 4th and 5th jobs;
//        release -> exactly 3 bursts on port1.
//  4. Simultaneous: job_i[0] pulses on the done_o[0] cycle with cnt[0]=1.
//     -> cnt[0] stays 1; a second burst on port0 follows.
//  5. Errors: force gnt_i=4'b0011, then gnt_i=4'b1000 with req_o=0,
//     then gnt_i=4'b0001 during BUSY.
//     -> err_o=1 after the first; no state change in any case.
//  6. Reset at beat 2 of a burst.
//     -> all outputs 0 immediately; no done_o; req_o=0 after release.
//  REQ_GNT_STATS_EN: after scenario 2, grant_cnt_o=4; after scenario 3, drop_cnt_o=2.

Source files
------------

// File: rtl/req_gnt_pkg.sv
// rtl/req_gnt_pkg.sv - shared state type and grant-check helper for the req/gnt requester
package req_gnt_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} rg_state_e;

  // Widest grant vector the one-hot helper accepts; callers zero-extend into it.
  localparam int ONEHOT_W = 32;

  // True when exactly one bit of v is set.
  function automatic logic onehot_chk(input logic [ONEHOT_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/pend_counter.sv
// rtl/pend_counter.sv - saturating per-port pending-job counter
module pend_counter
  import req_gnt_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf
);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max  = (cnt == CNT_W'(MAX_PEND));
  assign nonzero = (cnt != '0);

  // A job raises the count, a completion lowers it, both together cancel.
  // A job arriving with the counter already full is dropped and flagged for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= inc & ~dec & at_max;
      if (inc && !dec && !at_max) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/req_gnt_requester.sv
// rtl/req_gnt_requester.sv - requester side of req/gnt arbitration; REQ_GNT_STATS_EN adds grant/drop counters
module req_gnt_requester
  import req_gnt_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int BURST_LEN = 4,
  parameter int MAX_PEND  = 3,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] job_i,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic                 busy_o,
  output logic [PORT_W-1:0]    port_o,
  output logic [BEAT_W-1:0]    beat_o,
  output logic [NUM_PORTS-1:0] done_o,
  output logic [NUM_PORTS-1:0] ovf_o,
`ifdef REQ_GNT_STATS_EN
  output logic [31:0]          grant_cnt_o,
  output logic [15:0]          drop_cnt_o,
`endif
  output logic                 err_o
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);

  rg_state_e            state;
  rg_state_e            state_nx;
  logic [NUM_PORTS-1:0] nonzero;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 last_beat;
  logic                 accept;
  logic                 proto_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pend
      pend_counter #(
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W)
      ) u_pend (
        .clk     (clk),
        .reset   (reset),
        .inc     (job_i[gi]),
        .dec     (done_o[gi]),
        .nonzero (nonzero[gi]),
        .ovf     (ovf_o[gi])
      );
    end
  endgenerate

  assign busy_o    = (state == BUSY);
  assign last_beat = (beat_o == BEAT_W'(BURST_LEN - 1));
  assign req_o     = (state == IDLE) ? nonzero : '0;
  assign done_o    = (busy_o && last_beat) ? (NUM_PORTS'(1) << port_o) : '0;

  // One-hot grant to binary port index; only meaningful once the grant is known one-hot.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_i[i]) begin
        gnt_idx = gnt_idx | PORT_W'(i);
      end
    end
  end

  // Next-state: accept a clean grant in IDLE, run the burst in BUSY, flag any bad grant.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    proto_err = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_i != '0) begin
          if (onehot_chk(ONEHOT_W'(gnt_i)) && ((gnt_i & ~req_o) == '0)) begin
            accept   = 1'b1;
            state_nx = BUSY;
          end else begin
            proto_err = 1'b1;
          end
        end
      end
      BUSY: begin
        if (gnt_i != '0) begin
          proto_err = 1'b1;
        end
        if (last_beat) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Served port and beat index; both hold their last value once the burst ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_o <= '0;
      beat_o <= '0;
    end else if (accept) begin
      port_o <= gnt_idx;
      beat_o <= '0;
    end else if (busy_o && !last_beat) begin
      beat_o <= beat_o + BEAT_W'(1);
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (proto_err) begin
      err_o <= 1'b1;
    end
  end

`ifdef REQ_GNT_STATS_EN
  logic [16:0] drop_sum;
  logic [15:0] ovf_num;

  // Number of ports dropping a job this cycle.
  always_comb begin
    ovf_num = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ovf_num = ovf_num + 16'(ovf_o[i]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt_o} + {1'b0, ovf_num};

  // Accepted-grant counter (wrapping) and dropped-job counter (saturating).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (accept) begin
        grant_cnt_o <= grant_cnt_o + 32'd1;
      end
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_req_gnt_requester.sv
// tb/tb_req_gnt_requester.sv - self-checking bench for req_gnt_requester
module tb_req_gnt_requester;

  localparam int NP = 4;
  localparam int BL = 4;
  localparam int MP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  job_i = '0;
  logic [3:0]  req_o;
  logic [3:0]  gnt_i;
  logic        busy_o;
  logic [1:0]  port_o;
  logic [1:0]  beat_o;
  logic [3:0]  done_o;
  logic [3:0]  ovf_o;
  logic        err_o;
`ifdef REQ_GNT_STATS_EN
  logic [31:0] grant_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  logic        force_en = 1'b0;
  logic [3:0]  force_val = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Reference model: pending jobs per port, remaining beats of the current burst.
  int          m_pend[NP];
  bit          m_busy;
  int          m_port;
  int          m_left;
  int          m_beat;
  bit          m_err;
  logic [3:0]  m_ovf;
  int          m_grants;
  int          m_drops;

  always #5 clk = ~clk;

  function automatic logic [3:0] lowbit(input logic [3:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  // Fixed-priority arbiter (port 0 highest), overridable by the bench.
  assign gnt_i = force_en ? force_val : lowbit(req_o);

  req_gnt_requester #(.NUM_PORTS(NP), .BURST_LEN(BL), .MAX_PEND(MP)) dut (
    .clk(clk), .reset(reset), .job_i(job_i), .req_o(req_o), .gnt_i(gnt_i),
    .busy_o(busy_o), .port_o(port_o), .beat_o(beat_o), .done_o(done_o),
    .ovf_o(ovf_o),
`ifdef REQ_GNT_STATS_EN
    .grant_cnt_o(grant_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .err_o(err_o)
  );

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int i = 0; i < NP; i++) r[i] = (m_pend[i] > 0) && !m_busy;
    return r;
  endfunction

  function automatic logic [3:0] m_done();
    return (m_busy && m_left == 1) ? 4'(1 << m_port) : 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_pend[i] = 0;
    m_busy = 0; m_port = 0; m_left = 0; m_beat = 0; m_err = 0;
    m_ovf = '0; m_grants = 0; m_drops = 0;
  endtask

  // Advance the model across one rising edge with the given job vector.
  task automatic model_step(input logic [3:0] job);
    logic [3:0] r, g, fin;
    r = m_req();
    g = force_en ? force_val : lowbit(r);
    fin = '0;
    if (m_busy) begin
      if (g != 0) m_err = 1;
      if (m_left == 1) begin fin[m_port] = 1'b1; m_busy = 0; end
      else m_left--;
    end else if (g != 0) begin
      if ($countones(g) == 1 && (g & ~r) == 0) begin
        m_busy = 1; m_left = BL; m_grants++;
        for (int i = 0; i < NP; i++) if (g[i]) m_port = i;
      end else m_err = 1;
    end
    m_ovf = '0;
    for (int i = 0; i < NP; i++) begin
      if (job[i] && !fin[i]) begin
        if (m_pend[i] == MP) begin m_ovf[i] = 1'b1; m_drops++; end
        else m_pend[i]++;
      end else if (fin[i] && !job[i]) m_pend[i]--;
    end
    if (m_busy) m_beat = BL - m_left;
  endtask

  // Drive one cycle of jobs (called at a falling edge), return at the next falling edge.
  task automatic tick(input logic [3:0] job);
    job_i = job;
    model_step(job);
    @(negedge clk);
    job_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; job_i = '0; force_en = 1'b0; force_val = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({req_o, busy_o, port_o, beat_o, done_o, ovf_o, err_o} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {req_o, busy_o, port_o, beat_o, done_o, ovf_o, err_o});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(4'b0100);
    n_cmp++;
    if (req_o !== 4'b0100 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_req got=%b/%b exp=0100/0", req_o, busy_o);
    end
    for (int b = 0; b < BL; b++) begin
      tick(4'b0000);
      n_cmp++;
      if (busy_o !== 1'b1 || port_o !== 2'd2 || beat_o !== 2'(b) ||
          done_o !== ((b == BL - 1) ? 4'b0100 : 4'b0000) || req_o !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_beat%0d got busy=%b port=%0d beat=%0d done=%b req=%b", b, busy_o, port_o, beat_o, done_o, req_o);
      end
    end
    tick(4'b0000);
    n_cmp++;
    if (busy_o !== 1'b0 || req_o !== 4'b0000) begin
      n_fail++; $display("FAIL single_end got busy=%b req=%b exp 0/0000", busy_o, req_o);
    end
  endtask

  task automatic test_contention();
    int dcyc[NP];
    do_reset();
    for (int p = 0; p < NP; p++) dcyc[p] = -1;
    tick(4'b1111);
    for (int c = 2; c <= 25; c++) begin
      tick(4'b0000);
      for (int p = 0; p < NP; p++) if (done_o[p] && dcyc[p] < 0) dcyc[p] = c;
    end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (dcyc[p] !== 5 * (p + 1)) begin
        n_fail++; $display("FAIL contention_done_port%0d got cycle=%0d exp=%0d", p, dcyc[p], 5 * (p + 1));
      end
    end
`ifdef REQ_GNT_STATS_EN
    n_cmp++;
    if (grant_cnt_o !== 32'd4) begin
      n_fail++; $display("FAIL contention_grant_cnt got=%0d exp=4", grant_cnt_o);
    end
`endif
  endtask

  task automatic test_saturation();
    int nd;
    do_reset();
    force_en = 1'b1; force_val = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      tick(4'b0010);
      n_cmp++;
      if (ovf_o !== ((k >= 4) ? 4'b0010 : 4'b0000) || req_o !== 4'b0010) begin
        n_fail++; $display("FAIL sat_job%0d got ovf=%b req=%b", k, ovf_o, req_o);
      end
    end
    force_en = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      tick(4'b0000);
      if (done_o[1]) nd++;
    end
    n_cmp++;
    if (nd !== 3 || req_o !== 4'b0000) begin
      n_fail++; $display("FAIL sat_bursts got=%0d req=%b exp=3 req=0000", nd, req_o);
    end
`ifdef REQ_GNT_STATS_EN
    n_cmp++;
    if (drop_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL sat_drop_cnt got=%0d exp=2", drop_cnt_o);
    end
`endif
  endtask

  task automatic test_simultaneous();
    bit found;
    int nd;
    do_reset();
    tick(4'b0001);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (done_o[0]) begin tick(4'b0001); found = 1; end
      else tick(4'b0000);
    end
    n_cmp++;
    if (!found || req_o !== 4'b0001) begin
      n_fail++; $display("FAIL simul_reassert got found=%0d req=%b exp req=0001", found, req_o);
    end
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick(4'b0000);
      if (done_o[0]) nd++;
    end
    n_cmp++;
    if (nd !== 1 || req_o !== 4'b0000) begin
      n_fail++; $display("FAIL simul_second got bursts=%0d req=%b exp=1 req=0000", nd, req_o);
    end
  endtask

  task automatic test_errors();
    do_reset();
    force_en = 1'b1; force_val = 4'b0000;
    tick(4'b0001);
    force_val = 4'b0011;
    tick(4'b0000);
    n_cmp++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || req_o !== 4'b0001) begin
      n_fail++; $display("FAIL err_multi got err=%b busy=%b req=%b exp 1/0/0001", err_o, busy_o, req_o);
    end
    force_val = 4'b1000;
    tick(4'b0000);
    n_cmp++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || req_o !== 4'b0001) begin
      n_fail++; $display("FAIL err_noreq got err=%b busy=%b req=%b exp 1/0/0001", err_o, busy_o, req_o);
    end
    force_en = 1'b0;
    tick(4'b0000);
    force_en = 1'b1; force_val = 4'b0001;
    tick(4'b0000);
    n_cmp++;
    if (busy_o !== 1'b1 || port_o !== 2'd0 || beat_o !== 2'd1) begin
      n_fail++; $display("FAIL err_busy got busy=%b port=%0d beat=%0d exp 1/0/1", busy_o, port_o, beat_o);
    end
    force_en = 1'b0;
    tick(4'b0000);
    tick(4'b0000);
    n_cmp++;
    if (done_o !== 4'b0001 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_finish got done=%b err=%b exp 0001/1", done_o, err_o);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    do_reset();
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    n_cmp++;
    if (busy_o !== 1'b1 || beat_o !== 2'd2) begin
      n_fail++; $display("FAIL midrst_pre got busy=%b beat=%0d exp 1/2", busy_o, beat_o);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({req_o, busy_o, port_o, beat_o, done_o, ovf_o, err_o} !== 17'd0) begin
      n_fail++; $display("FAIL midrst_outputs got=%h exp=0", {req_o, busy_o, port_o, beat_o, done_o, ovf_o, err_o});
    end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      tick(4'b0000);
      if (done_o != 0 || busy_o) nd++;
    end
    n_cmp++;
    if (nd !== 0 || req_o !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_after got activity=%0d req=%b exp 0/0000", nd, req_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] job;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      job = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (c >= 300 && $urandom_range(0, 7) == 0) begin
        force_en = 1'b1; force_val = 4'($urandom_range(0, 15));
      end else begin
        force_en = 1'b0; force_val = '0;
      end
      tick(job);
      n_cmp++;
      if ({req_o, busy_o, done_o, ovf_o, err_o} !== {m_req(), m_busy, m_done(), m_ovf, m_err}) begin
        n_fail++;
        $display("FAIL rand_c%0d got req=%b busy=%b done=%b ovf=%b err=%b exp req=%b busy=%b done=%b ovf=%b err=%b",
                 c, req_o, busy_o, done_o, ovf_o, err_o, m_req(), m_busy, m_done(), m_ovf, m_err);
      end
      n_cmp++;
      if ({port_o, beat_o} !== {2'(m_port), 2'(m_beat)}) begin
        n_fail++; $display("FAIL rand_pb_c%0d got port=%0d beat=%0d exp port=%0d beat=%0d", c, port_o, beat_o, m_port, m_beat);
      end
    end
    force_en = 1'b0;
`ifdef REQ_GNT_STATS_EN
    n_cmp++;
    if (grant_cnt_o !== 32'(m_grants) || drop_cnt_o !== 16'(m_drops)) begin
      n_fail++; $display("FAIL rand_stats got g=%0d d=%0d exp g=%0d d=%0d", grant_cnt_o, drop_cnt_o, m_grants, m_drops);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_saturation();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
